// File: rtl/ej1_pkg.sv
// Shared definitions for the I/S serial link: line levels and the
// transmitter state encoding used by both ends.
package ej1_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Bit counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ej1_shift_reg.sv
// Parallel-load, shift-right register presenting its LSB; load has priority
// over shift so an accept in the STOP cycle always captures the new word.
module ej1_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_shift;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign o_lsb = r_shift[0];

endmodule

// File: rtl/ej1_serial_tx.sv
// Framed serial transmitter: start, WIDTH data bits LSB first, optional
// even-parity bit, stop. I/S/busy are registered; data_ready decodes state.
module ej1_serial_tx
  import ej1_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             I,
  output logic             S,
  output logic             busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_parity;
  logic           r_i;
  logic           r_s;
  logic           r_busy;

  logic           w_accept;
  logic           w_shift;
  logic           w_lsb;

  assign data_ready = (r_state == IDLE) || (r_state == STOP);
  assign w_accept   = data_valid & data_ready;
  // The register shifts on the same edge its LSB is copied into r_i.
  assign w_shift    = (r_state == START) || (r_state == DATA);

  ej1_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_data  (data_in),
    .i_shift (w_shift),
    .o_lsb   (w_lsb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_i      <= IDLE_LEVEL;
      r_s      <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, STOP: begin
          if (w_accept) begin
            r_state  <= START;
            r_cnt    <= '0;
            r_parity <= ^data_in;
            r_i      <= START_LEVEL;
            r_s      <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_i     <= IDLE_LEVEL;
            r_s     <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        START: begin
          r_state <= DATA;
          r_cnt   <= '0;
          r_i     <= w_lsb;
          r_s     <= 1'b0;
        end
        DATA: begin
          if (r_cnt == LAST) begin
            if (PARITY_EN) begin
              r_state <= PARITY;
              r_i     <= r_parity;
            end else begin
              r_state <= STOP;
              r_i     <= STOP_LEVEL;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_i   <= w_lsb;
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_i     <= STOP_LEVEL;
        end
        default: begin
          r_state <= IDLE;
          r_i     <= IDLE_LEVEL;
          r_s     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign I    = r_i;
  assign S    = r_s;
  assign busy = r_busy;

endmodule

// File: tb/tb_ej1_serial_tx.sv
// Directed bench for ej1_serial_tx: hand-computed frames, back-to-back,
// mid-frame reset, a no-parity instance and a randomised loopback decode.
module tb_ej1_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       I;
  logic       S;
  logic       busy;

  logic [7:0] np_data_in;
  logic       np_valid;
  logic       np_ready;
  logic       np_I;
  logic       np_S;
  logic       np_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ej1_serial_tx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .I          (I),
    .S          (S),
    .busy       (busy)
  );

  ej1_serial_tx #(.WIDTH(8), .PARITY_EN(1'b0)) dut_np (
    .clk        (clk),
    .reset      (reset),
    .data_in    (np_data_in),
    .data_valid (np_valid),
    .data_ready (np_ready),
    .I          (np_I),
    .S          (np_S),
    .busy       (np_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s_I", tag), I, 1);
    check($sformatf("%s_S", tag), S, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_rdy", tag), data_ready, 1);
  endtask

  // Called in the START cycle; returns in the STOP cycle. vec[k] = I at cycle k.
  task automatic frame_check(input string tag, input logic [10:0] vec);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) step();
      check($sformatf("%s_I%0d", tag, k), I, vec[k]);
      check($sformatf("%s_S%0d", tag, k), S, (k == 0) ? 1 : 0);
      check($sformatf("%s_busy%0d", tag, k), busy, 1);
      check($sformatf("%s_rdy%0d", tag, k), data_ready, (k == 10) ? 1 : 0);
    end
  endtask

  initial begin
    logic [9:0] np_vec;
    logic [7:0] w;
    logic [7:0] rx;
    logic       p;
    logic       stp;
    int         gap;

    reset = 1'b1; data_valid = 1'b0; data_in = '0;
    np_valid = 1'b0; np_data_in = '0;
    step();
    check_idle("rst");
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_idle($sformatf("idle%0d", c));
    end

    // A5: start, 1,0,1,0,0,1,0,1, parity 0, stop
    data_valid = 1'b1; data_in = 8'hA5;
    step();
    data_valid = 1'b0; data_in = 8'hXX;
    frame_check("a5", 11'b10101001010);
    step();
    check_idle("a5_after");

    // 07: three ones -> parity 1
    data_valid = 1'b1; data_in = 8'h07;
    step();
    data_valid = 1'b0;
    frame_check("p07", 11'b11000001110);
    step();
    check_idle("p07_after");

    // No-parity instance: 10-cycle frame, stop right after bit 7
    np_vec = 10'b1000001110;
    np_valid = 1'b1; np_data_in = 8'h07;
    step();
    np_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      check($sformatf("np_I%0d", k), np_I, np_vec[k]);
      check($sformatf("np_S%0d", k), np_S, (k == 0) ? 1 : 0);
      check($sformatf("np_busy%0d", k), np_busy, 1);
      check($sformatf("np_rdy%0d", k), np_ready, (k == 9) ? 1 : 0);
    end
    step();
    check($sformatf("np_after_busy"), np_busy, 0);
    check($sformatf("np_after_I"), np_I, 1);
    check($sformatf("np_after_rdy"), np_ready, 1);

    // Back-to-back with data_valid held high: 01 then 80
    data_valid = 1'b1; data_in = 8'h01;
    step();
    data_in = 8'h80;
    frame_check("b01", 11'b11000000010);
    step();
    data_valid = 1'b0;
    frame_check("b80", 11'b11100000000);
    step();
    check_idle("b2b_after");

    // Reset during the 4th data bit of FF, with data_valid high on that edge
    data_valid = 1'b1; data_in = 8'hFF;
    step();
    data_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("ff_bit3_I", I, 1);
    check("ff_bit3_busy", busy, 1);
    reset = 1'b1; data_valid = 1'b1; data_in = 8'h00;
    step();
    check_idle("midrst");
    reset = 1'b0;
    step();
    data_valid = 1'b0;
    frame_check("f00", 11'b10000000000);
    step();
    check_idle("f00_after");

    // Loopback: decode I/S as a receiver would, random words and gaps
    for (int f = 0; f < 1000; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      w = 8'($urandom);
      data_valid = 1'b1; data_in = w;
      step();
      data_valid = 1'b0; data_in = 8'hXX;
      check($sformatf("lb%0d_start", f), {S, I}, 2'b10);
      for (int b = 0; b < 8; b++) begin
        step();
        rx[b] = I;
      end
      step();
      p = I;
      step();
      stp = I;
      check($sformatf("lb%0d_word", f), rx, w);
      check($sformatf("lb%0d_par", f), ^{rx, p}, 0);
      check($sformatf("lb%0d_stop", f), {S, stp}, 2'b01);
    end
    step();
    check_idle("lb_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
